// File: rtl/sal_timing_cfg_pkg.sv
// Shared register map, state encodings and timing defaults for the SAL DDR2 timing block.
// T_*_VALUE normally come from SAL_DDR2_PARAMS.svh; the fallbacks below keep the slice standalone.
`ifndef T_RCD_VALUE
`define T_RCD_VALUE 8'd4
`endif
`ifndef T_RP_VALUE
`define T_RP_VALUE 8'd4
`endif
`ifndef T_RAS_VALUE
`define T_RAS_VALUE 8'd12
`endif
`ifndef T_RFC_VALUE
`define T_RFC_VALUE 8'd51
`endif
`ifndef T_RTP_VALUE
`define T_RTP_VALUE 8'd2
`endif
`ifndef T_WTP_VALUE
`define T_WTP_VALUE 8'd6
`endif
`ifndef T_RRD_VALUE
`define T_RRD_VALUE 8'd3
`endif
`ifndef T_CCD_VALUE
`define T_CCD_VALUE 8'd2
`endif
`ifndef T_WTR_VALUE
`define T_WTR_VALUE 8'd3
`endif
`ifndef T_RTW_VALUE
`define T_RTW_VALUE 8'd4
`endif

package sal_timing_cfg_pkg;

   localparam int unsigned TIMING_FIELD_W = 8;
   localparam int unsigned NUM_TIMING     = 10;

   localparam logic [11:0] ADDR_ID     = 12'h000;
   localparam logic [11:0] ADDR_CTRL   = 12'h004;
   localparam logic [11:0] ADDR_STATUS = 12'h008;
   localparam logic [11:0] ADDR_SHADOW = 12'h010;

   typedef enum logic [3:0] {
      T_RCD_IDX, T_RP_IDX, T_RAS_IDX, T_RFC_IDX, T_RTP_IDX,
      T_WTP_IDX, T_RRD_IDX, T_CCD_IDX, T_WTR_IDX, T_RTW_IDX
   } timing_idx_e;

   typedef enum logic [1:0] {IDLE, WAIT, RESP} apb_state_e;
   typedef enum logic [1:0] {C_IDLE, C_PEND, C_APPLY} commit_state_e;

   typedef struct packed {
      logic [TIMING_FIELD_W-1:0] t_rcd;
      logic [TIMING_FIELD_W-1:0] t_rp;
      logic [TIMING_FIELD_W-1:0] t_ras;
      logic [TIMING_FIELD_W-1:0] t_rfc;
      logic [TIMING_FIELD_W-1:0] t_rtp;
      logic [TIMING_FIELD_W-1:0] t_wtp;
      logic [TIMING_FIELD_W-1:0] t_rrd;
      logic [TIMING_FIELD_W-1:0] t_ccd;
      logic [TIMING_FIELD_W-1:0] t_wtr;
      logic [TIMING_FIELD_W-1:0] t_rtw;
   } timing_t;

   localparam timing_t TIMING_DEFAULT = '{
      t_rcd: TIMING_FIELD_W'(`T_RCD_VALUE), t_rp:  TIMING_FIELD_W'(`T_RP_VALUE),
      t_ras: TIMING_FIELD_W'(`T_RAS_VALUE), t_rfc: TIMING_FIELD_W'(`T_RFC_VALUE),
      t_rtp: TIMING_FIELD_W'(`T_RTP_VALUE), t_wtp: TIMING_FIELD_W'(`T_WTP_VALUE),
      t_rrd: TIMING_FIELD_W'(`T_RRD_VALUE), t_ccd: TIMING_FIELD_W'(`T_CCD_VALUE),
      t_wtr: TIMING_FIELD_W'(`T_WTR_VALUE), t_rtw: TIMING_FIELD_W'(`T_RTW_VALUE)
   };

   // Field idx of the default struct; t_rcd sits in the most significant slot.
   function automatic logic [TIMING_FIELD_W-1:0] timing_default(input int unsigned idx);
      logic [NUM_TIMING*TIMING_FIELD_W-1:0] flat;
      flat = TIMING_DEFAULT;
      return flat[(NUM_TIMING-1-idx)*TIMING_FIELD_W +: TIMING_FIELD_W];
   endfunction

endpackage

// File: rtl/sal_timing_cfg_if.sv
// APB slave bus and the two active-timing output bundles of the SAL timing block.

interface APB_IF;
   logic        psel;
   logic        penable;
   logic [11:0] paddr;
   logic        pwrite;
   logic [31:0] pwdata;
   logic [31:0] prdata;
   logic        pready;
   logic        pslverr;

   modport master (output psel, penable, paddr, pwrite, pwdata, input prdata, pready, pslverr);
   modport slave  (input psel, penable, paddr, pwrite, pwdata, output prdata, pready, pslverr);
endinterface

interface BK_TIMING_IF #(parameter int unsigned TIMING_W = 8);
   logic [TIMING_W-1:0] t_rcd;
   logic [TIMING_W-1:0] t_rp;
   logic [TIMING_W-1:0] t_ras;
   logic [TIMING_W-1:0] t_rfc;
   logic [TIMING_W-1:0] t_rtp;
   logic [TIMING_W-1:0] t_wtp;

   modport master (output t_rcd, t_rp, t_ras, t_rfc, t_rtp, t_wtp);
   modport slave  (input t_rcd, t_rp, t_ras, t_rfc, t_rtp, t_wtp);
endinterface

interface SCHED_TIMING_IF #(parameter int unsigned TIMING_W = 8);
   logic [TIMING_W-1:0] t_rrd;
   logic [TIMING_W-1:0] t_ccd;
   logic [TIMING_W-1:0] t_wtr;
   logic [TIMING_W-1:0] t_rtw;

   modport master (output t_rrd, t_ccd, t_wtr, t_rtw);
   modport slave  (input t_rrd, t_ccd, t_wtr, t_rtw);
endinterface

// File: rtl/sal_apb_slv.sv
// Fixed-latency APB slave: latches the access, waits one cycle, then responds for one cycle.
// Register strobes are valid only in RESP; writes land on the edge that ends RESP.

module sal_apb_slv
   import sal_timing_cfg_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   APB_IF.slave        apb,
   output logic        wr_en,
   output logic        rd_en,
   output logic [11:0] addr,
   output logic [31:0] wdata,
   input  logic [31:0] rdata,
   input  logic        err
);

   apb_state_e  state_q;
   logic        write_q;
   logic        pready_q;
   logic [11:0] addr_q;
   logic [31:0] wdata_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         write_q  <= 1'b0;
         pready_q <= 1'b0;
         addr_q   <= '0;
         wdata_q  <= '0;
      end else begin
         unique case (state_q)
            IDLE: begin
               if (apb.psel && apb.penable) begin
                  state_q <= WAIT;
                  write_q <= apb.pwrite;
                  addr_q  <= apb.paddr;
                  wdata_q <= apb.pwdata;
               end
            end
            WAIT: begin
               state_q  <= RESP;
               pready_q <= 1'b1;
            end
            RESP: begin
               state_q  <= IDLE;
               pready_q <= 1'b0;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign wr_en       = (state_q == RESP) && write_q;
   assign rd_en       = (state_q == RESP) && !write_q;
   assign addr        = addr_q;
   assign wdata       = wdata_q;
   assign apb.pready  = pready_q;
   assign apb.prdata  = rd_en ? rdata : '0;
   assign apb.pslverr = (state_q == RESP) && err;

endmodule

// File: rtl/sal_timing_cfg.sv
// APB-programmed DRAM timing shadow/active registers with an idle-gated atomic commit.
// Optional SAL_TIMING_CFG_CHECK_EN adds a sanity check on the shadow set before applying.

module sal_timing_cfg
   import sal_timing_cfg_pkg::*;
#(
   parameter int unsigned TIMING_W = 8,
   parameter logic [31:0] ID_VALUE = 32'h5A1C_0200
) (
   input  logic           clk,
   input  logic           rst_n,
   APB_IF.slave           apb_if,
   input  logic           ctrl_idle,
   BK_TIMING_IF.master    bk_timing_if,
   SCHED_TIMING_IF.master sched_timing_if,
   output logic           cfg_update
);

   logic          wr_en, rd_en, err;
   logic [11:0]   addr, sh_off;
   logic [31:0]   wdata, rdata;
   logic [3:0]    sh_idx;
   logic          is_shadow, mapped, pending, check_ok, check_err;
   logic          commit_wr, lock_wr, shadow_wr;
   logic          locked_q, cfg_update_q;
   commit_state_e cstate_q;
   logic [TIMING_W-1:0] shadow_q [NUM_TIMING];
   logic [TIMING_W-1:0] active_q [NUM_TIMING];
   logic          unused_wdata;

   sal_apb_slv u_apb (
      .clk   (clk),
      .rst_n (rst_n),
      .apb   (apb_if),
      .wr_en (wr_en),
      .rd_en (rd_en),
      .addr  (addr),
      .wdata (wdata),
      .rdata (rdata),
      .err   (err)
   );

   assign unused_wdata = ^wdata[31:TIMING_W];

   always_comb begin
      // Offsets below the shadow window wrap high and fall out of range.
      sh_off    = addr - ADDR_SHADOW;
      sh_idx    = sh_off[5:2];
      is_shadow = (sh_off < 12'(NUM_TIMING * 4)) && (sh_off[1:0] == 2'b00);
      mapped    = is_shadow || (addr inside {ADDR_ID, ADDR_CTRL, ADDR_STATUS});
      pending   = (cstate_q == C_PEND);
      err       = (rd_en || wr_en) &&
                  (!mapped || (wr_en && is_shadow && (locked_q || pending)));
      commit_wr = wr_en && (addr == ADDR_CTRL) && wdata[0];
      lock_wr   = wr_en && (addr == ADDR_CTRL) && wdata[1];
      shadow_wr = wr_en && is_shadow && !err;
      rdata     = '0;
      if (rd_en && !err) begin
         if (is_shadow) begin
            rdata = 32'(shadow_q[sh_idx]);
         end else begin
            case (addr)
               ADDR_ID:     rdata = ID_VALUE;
               ADDR_CTRL:   rdata = {30'b0, locked_q, 1'b0};
               ADDR_STATUS: rdata = {29'b0, check_err, locked_q, pending};
               default:     rdata = '0;
            endcase
         end
      end
   end

`ifdef SAL_TIMING_CFG_CHECK_EN
   logic check_err_q;

   always_comb begin
      check_ok = shadow_q[T_RAS_IDX] >= shadow_q[T_RCD_IDX];
      for (int unsigned i = 0; i < NUM_TIMING; i++) begin
         if (shadow_q[i] == '0) check_ok = 1'b0;
      end
   end

   assign check_err = check_err_q;
`else
   assign check_ok  = 1'b1;
   assign check_err = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         locked_q <= 1'b0;
         for (int unsigned i = 0; i < NUM_TIMING; i++) shadow_q[i] <= TIMING_W'(timing_default(i));
      end else begin
         if (lock_wr) locked_q <= 1'b1;
         if (shadow_wr) shadow_q[sh_idx] <= wdata[TIMING_W-1:0];
      end
   end

   // COMMIT arriving while pending is dropped; one landing in C_APPLY re-arms the commit.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cstate_q     <= C_IDLE;
         cfg_update_q <= 1'b0;
         for (int unsigned i = 0; i < NUM_TIMING; i++) active_q[i] <= TIMING_W'(timing_default(i));
`ifdef SAL_TIMING_CFG_CHECK_EN
         check_err_q  <= 1'b0;
`endif
      end else begin
         cfg_update_q <= 1'b0;
         unique case (cstate_q)
            C_IDLE: if (commit_wr) cstate_q <= C_PEND;
            C_PEND: begin
               if (ctrl_idle) begin
                  if (check_ok) begin
                     cstate_q     <= C_APPLY;
                     cfg_update_q <= 1'b1;
                  end else begin
                     cstate_q    <= C_IDLE;
`ifdef SAL_TIMING_CFG_CHECK_EN
                     check_err_q <= 1'b1;
`endif
                  end
               end
            end
            C_APPLY: begin
               active_q <= shadow_q;
               cstate_q <= commit_wr ? C_PEND : C_IDLE;
`ifdef SAL_TIMING_CFG_CHECK_EN
               check_err_q <= 1'b0;
`endif
            end
            default: cstate_q <= C_IDLE;
         endcase
      end
   end

   assign cfg_update            = cfg_update_q;
   assign bk_timing_if.t_rcd    = active_q[T_RCD_IDX];
   assign bk_timing_if.t_rp     = active_q[T_RP_IDX];
   assign bk_timing_if.t_ras    = active_q[T_RAS_IDX];
   assign bk_timing_if.t_rfc    = active_q[T_RFC_IDX];
   assign bk_timing_if.t_rtp    = active_q[T_RTP_IDX];
   assign bk_timing_if.t_wtp    = active_q[T_WTP_IDX];
   assign sched_timing_if.t_rrd = active_q[T_RRD_IDX];
   assign sched_timing_if.t_ccd = active_q[T_CCD_IDX];
   assign sched_timing_if.t_wtr = active_q[T_WTR_IDX];
   assign sched_timing_if.t_rtw = active_q[T_RTW_IDX];

endmodule

// File: tb/tb_sal_timing_cfg.sv
// Directed bench for sal_timing_cfg: APB accesses scored through an expectation queue.

module tb_sal_timing_cfg;
   import sal_timing_cfg_pkg::*;

   localparam logic [31:0] ID = 32'h5A1C_0200;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic ctrl_idle = 1'b1;
   logic cfg_update;
   int   checks = 0;
   int   failures = 0;
   int   upd_count = 0;
   int   base;

   APB_IF apb ();
   BK_TIMING_IF #(.TIMING_W(8)) bk ();
   SCHED_TIMING_IF #(.TIMING_W(8)) sc ();

   sal_timing_cfg #(.TIMING_W(8), .ID_VALUE(ID)) dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .apb_if          (apb),
      .ctrl_idle       (ctrl_idle),
      .bk_timing_if    (bk),
      .sched_timing_if (sc),
      .cfg_update      (cfg_update)
   );

   always #5 clk = ~clk;

   always @(negedge clk) if (cfg_update === 1'b1) upd_count++;

   logic [7:0] act [NUM_TIMING];
   logic [7:0] dflt [NUM_TIMING];
   assign act[0] = bk.t_rcd;
   assign act[1] = bk.t_rp;
   assign act[2] = bk.t_ras;
   assign act[3] = bk.t_rfc;
   assign act[4] = bk.t_rtp;
   assign act[5] = bk.t_wtp;
   assign act[6] = sc.t_rrd;
   assign act[7] = sc.t_ccd;
   assign act[8] = sc.t_wtr;
   assign act[9] = sc.t_rtw;

   typedef struct {
      string       tag;
      logic [31:0] data;
      logic        err;
   } exp_t;
   exp_t sb[$];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic apb_op(input string tag, input logic wr, input logic [11:0] a,
                         input logic [31:0] d, input logic [31:0] exp_data, input logic exp_err);
      exp_t        e;
      logic [31:0] rd;
      logic        er;
      int          lat;
      sb.push_back('{tag, exp_data, exp_err});
      @(posedge clk); #1;
      apb.psel = 1'b1; apb.penable = 1'b0; apb.pwrite = wr; apb.paddr = a; apb.pwdata = d;
      @(posedge clk); #1;
      apb.penable = 1'b1;
      lat = 0;
      @(negedge clk);
      while (apb.pready !== 1'b1 && lat < 8) begin
         @(negedge clk);
         lat++;
      end
      rd = apb.prdata;
      er = apb.pslverr;
      @(posedge clk); #1;
      apb.psel = 1'b0; apb.penable = 1'b0;
      e = sb.pop_front();
      check({e.tag, "_lat"}, 32'(lat), 32'd2);
      check({e.tag, "_err"}, 32'(er), 32'(e.err));
      if (!wr) check({e.tag, "_data"}, rd, e.data);
   endtask

   task automatic expect_update(input string tag, input int exp_cycles);
      int n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (cfg_update !== 1'b1 && n < 8);
      check(tag, 32'(n), 32'(exp_cycles));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      dflt = '{TIMING_DEFAULT.t_rcd, TIMING_DEFAULT.t_rp, TIMING_DEFAULT.t_ras,
               TIMING_DEFAULT.t_rfc, TIMING_DEFAULT.t_rtp, TIMING_DEFAULT.t_wtp,
               TIMING_DEFAULT.t_rrd, TIMING_DEFAULT.t_ccd, TIMING_DEFAULT.t_wtr,
               TIMING_DEFAULT.t_rtw};
      apb.psel = 1'b0; apb.penable = 1'b0; apb.pwrite = 1'b0;
      apb.paddr = '0; apb.pwdata = '0;

      // Reset state
      repeat (2) @(negedge clk);
      check("rst_pready", 32'(apb.pready), 32'd0);
      check("rst_pslverr", 32'(apb.pslverr), 32'd0);
      check("rst_prdata", apb.prdata, 32'd0);
      check("rst_cfg_update", 32'(cfg_update), 32'd0);
      for (int i = 0; i < NUM_TIMING; i++) check($sformatf("rst_act%0d", i), 32'(act[i]), 32'(dflt[i]));
      rst_n = 1'b1;

      apb_op("rd_id", 1'b0, 12'h000, 32'd0, ID, 1'b0);
      apb_op("rd_rcd", 1'b0, 12'h010, 32'd0, 32'(dflt[0]), 1'b0);

      // Basic commit with the controller idle
      apb_op("wr_rcd5", 1'b1, 12'h010, 32'd5, 32'd0, 1'b0);
      apb_op("wr_ras12", 1'b1, 12'h018, 32'd12, 32'd0, 1'b0);
      base = upd_count;
      apb_op("commit1", 1'b1, 12'h004, 32'd1, 32'd0, 1'b0);
      expect_update("upd_lat1", 2);
      repeat (3) @(negedge clk);
      check("upd_once1", 32'(upd_count - base), 32'd1);
      check("act_rcd5", 32'(act[0]), 32'd5);
      check("act_ras12", 32'(act[2]), 32'd12);

      // Commit held off by a busy controller
      apb_op("wr_rcd7", 1'b1, 12'h010, 32'd7, 32'd0, 1'b0);
      ctrl_idle = 1'b0;
      base = upd_count;
      apb_op("commit2", 1'b1, 12'h004, 32'd1, 32'd0, 1'b0);
      repeat (20) @(negedge clk);
      apb_op("rd_status_pend", 1'b0, 12'h008, 32'd0, 32'd1, 1'b0);
      check("hold_rcd", 32'(act[0]), 32'd5);
      check("hold_upd", 32'(upd_count - base), 32'd0);
      apb_op("wr_rp_pend", 1'b1, 12'h014, 32'd9, 32'd0, 1'b1);
      ctrl_idle = 1'b1;
      expect_update("upd_lat2", 2);
      repeat (2) @(negedge clk);
      check("act_rcd7", 32'(act[0]), 32'd7);
      check("act_rp_dflt", 32'(act[1]), 32'(dflt[1]));
      apb_op("rd_rp", 1'b0, 12'h014, 32'd0, 32'(dflt[1]), 1'b0);
      apb_op("rd_status_idle", 1'b0, 12'h008, 32'd0, 32'd0, 1'b0);

`ifdef SAL_TIMING_CFG_CHECK_EN
      apb_op("wr_ras3", 1'b1, 12'h018, 32'd3, 32'd0, 1'b0);
      base = upd_count;
      apb_op("commit_bad", 1'b1, 12'h004, 32'd1, 32'd0, 1'b0);
      repeat (6) @(negedge clk);
      check("bad_no_upd", 32'(upd_count - base), 32'd0);
      check("bad_ras_hold", 32'(act[2]), 32'd12);
      apb_op("rd_status_cerr", 1'b0, 12'h008, 32'd0, 32'd4, 1'b0);
      apb_op("wr_ras12b", 1'b1, 12'h018, 32'd12, 32'd0, 1'b0);
      apb_op("commit_good", 1'b1, 12'h004, 32'd1, 32'd0, 1'b0);
      expect_update("upd_lat_good", 2);
      apb_op("rd_status_clr", 1'b0, 12'h008, 32'd0, 32'd0, 1'b0);
`endif

      // Lock and address decode errors
      apb_op("wr_lock", 1'b1, 12'h004, 32'd2, 32'd0, 1'b0);
      apb_op("rd_status_lock", 1'b0, 12'h008, 32'd0, 32'd2, 1'b0);
      apb_op("wr_wtr_lock", 1'b1, 12'h030, 32'd33, 32'd0, 1'b1);
      apb_op("rd_wtr", 1'b0, 12'h030, 32'd0, 32'(dflt[8]), 1'b0);
      apb_op("rd_unmapped", 1'b0, 12'h040, 32'd0, 32'd0, 1'b1);
      apb_op("rd_gap", 1'b0, 12'h00C, 32'd0, 32'd0, 1'b1);
      apb_op("commit_locked", 1'b1, 12'h004, 32'd1, 32'd0, 1'b0);
      expect_update("upd_lat_locked", 2);

      // Reset while a commit is pending
      ctrl_idle = 1'b0;
      apb_op("commit_rst", 1'b1, 12'h004, 32'd1, 32'd0, 1'b0);
      apb_op("rd_status_pl", 1'b0, 12'h008, 32'd0, 32'd3, 1'b0);
      rst_n = 1'b0;
      #2;
      check("rst2_cfg_update", 32'(cfg_update), 32'd0);
      check("rst2_rcd", 32'(act[0]), 32'(dflt[0]));
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      ctrl_idle = 1'b1;
      base = upd_count;
      apb_op("rd_status_rst", 1'b0, 12'h008, 32'd0, 32'd0, 1'b0);
      for (int i = 0; i < NUM_TIMING; i++) check($sformatf("rst2_act%0d", i), 32'(act[i]), 32'(dflt[i]));
      apb_op("rd_rcd_rst", 1'b0, 12'h010, 32'd0, 32'(dflt[0]), 1'b0);
      apb_op("wr_rp_unlocked", 1'b1, 12'h014, 32'd9, 32'd0, 1'b0);
      check("rst2_no_upd", 32'(upd_count - base), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/sal_timing_cfg.md
# sal_timing_cfg

APB-programmable DRAM timing configuration block for the SAL DDR2 controller. Software writes timing values into shadow registers over APB and requests a commit. The block then transfers all shadow values atomically to the active registers that drive the bank and scheduler timing interfaces. The transfer happens only while the controller reports idle, so timing never changes mid-command. Active and shadow registers reset to the `T_*_VALUE` defaults from `SAL_DDR2_PARAMS.svh`.

## Interface
- TIMING_W, 8, width of every timing field; must equal the field width of BK_TIMING_IF/SCHED_TIMING_IF
- ID_VALUE, 32'h5A1C_0200, value returned by the ID register
- clk  input  1  controller clock
- rst_n  input  1  asynchronous active-low reset
- apb_if  slave  APB_IF  psel, penable, paddr[11:0], pwrite, pwdata[31:0] in; prdata[31:0], pready, pslverr out
- ctrl_idle  input  1  controller has no open command in flight; safe to change timing
- bk_timing_if  output  BK_TIMING_IF  active t_rcd, t_rp, t_ras, t_rfc, t_rtp, t_wtp
- sched_timing_if  output  SCHED_TIMING_IF  active t_rrd, t_ccd, t_wtr, t_rtw
- cfg_update  output  1  one-cycle pulse in the cycle the active registers take new values

## Operation
- Register map (word offsets), all others unmapped:
  - 0x00 ID, RO.
  - 0x04 CTRL: bit0 COMMIT (W1S, self-clearing); bit1 LOCK (W1S, cleared only by reset).
  - 0x08 STATUS, RO: bit0 pending, bit1 locked, bit2 check_err.
  - 0x10+4*i shadow timing i, RW, [TIMING_W-1:0], upper bits read 0. Order i=0..9: t_rcd, t_rp, t_ras, t_rfc, t_rtp, t_wtp, t_rrd, t_ccd, t_wtr, t_rtw.
- APB FSM states: IDLE, WAIT, RESP.
  - IDLE→WAIT on psel&penable.
  - WAIT→RESP unconditionally.
  - In RESP: pready=1 and prdata/pslverr are valid; the write takes effect at that edge. RESP→IDLE.
- pslverr=1, with the write ignored and read data 0, when any of these holds:
  - the address is unmapped;
  - a shadow write occurs while locked;
  - a shadow write occurs while pending.
- Commit FSM states: C_IDLE, C_PEND, C_APPLY.
  - C_IDLE→C_PEND on a COMMIT write.
  - C_PEND→C_APPLY in the cycle ctrl_idle=1 is sampled.
  - In C_APPLY: active regs ← shadow, cfg_update=1, pending clears. C_APPLY→C_IDLE.
- COMMIT while pending: ignored, no error. COMMIT while locked: accepted; LOCK blocks only shadow writes.
- Reset mid-operation: both FSMs go to idle, pending clears, LOCK clears, and all registers return to their defaults immediately.

## Timing
- Reset values: pready=0, pslverr=0, prdata=0, cfg_update=0; active = shadow = `T_*_VALUE`.
- APB access takes 3 cycles after penable is asserted: pready rises 2 cycles after the first cycle of penable.
- A register read returns the value at the RESP edge. A shadow write in the same cycle is impossible because only one APB access is in flight at a time.
- Commit latency: the COMMIT write edge, then at least 1 cycle in C_PEND, then C_APPLY. New values are visible on the timing interfaces the cycle after C_APPLY. With ctrl_idle held high the minimum is 2 cycles after the write edge.
- If ctrl_idle is low, the block waits indefinitely in C_PEND. No timeout.

## Configuration
- SAL_TIMING_CFG_CHECK_EN defined:
  - In C_PEND, apply is allowed only if every shadow field is nonzero and t_ras ≥ t_rcd.
  - If the check fails, the block returns to C_IDLE without applying, with no cfg_update, and sets check_err.
  - check_err clears on the next successful apply.
- Undefined: no check is done, and check_err reads 0.

## Structure
- Package sal_timing_cfg_pkg contains:
  - address offset localparams;
  - the field index enum (T_RCD_IDX…T_RTW_IDX, NUM_TIMING=10);
  - the APB and commit state enums;
  - a packed struct holding all 10 timing fields.
- One sub-module, sal_apb_slv, holds the APB FSM. It produces wr_en/rd_en/addr/wdata strobes in RESP and accepts rdata/err back.
- The register file and commit FSM live in the top module.

## Test plan
- Reset, then read 0x00 and 0x10 → ID_VALUE and `T_RCD_VALUE`; pslverr=0; pready high exactly 2 cycles after penable.
- Write 0x10=5 and 0x18=12, COMMIT with ctrl_idle=1 → cfg_update pulses once 2 cycles after the write edge; bk_timing_if.t_rcd=5 and t_ras=12.
- COMMIT with ctrl_idle=0 for 20 cycles → STATUS=0x1 and outputs unchanged. Write 0x14 → pslverr=1. Raise ctrl_idle → apply in the next cycle.
- Write LOCK, then write 0x30 → pslverr=1 and shadow unchanged. Read 0x40 → pslverr=1 with prdata=0.
- With SAL_TIMING_CFG_CHECK_EN: shadow t_ras=3, t_rcd=5, COMMIT → no cfg_update, STATUS bit2=1, outputs unchanged.
- Assert rst_n low while in C_PEND → STATUS=0 and all active fields equal their `T_*_VALUE` after release.
